// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode encodings, instruction field
// positions and fetch FSM state encodings.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W    = 28;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned OPCODE_MSB = 27;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned IMM_MSB    = 23;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_BLE = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_LED = 4'h6;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;

  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, instruction register, branch flush and, with
// FETCH_NOP_DELAY_EN defined, a NOP-immediate stall counter.
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter int unsigned DELAY_W  = 24
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget
);

  logic [15:0] pc;
  logic [27:0] ir;
  logic        valid;
  logic [1:0]  state;
  logic        advance;

  assign advance      = (state == ST_FETCH) && (!valid || iReady);
  assign oAddress     = pc;
  assign oInstruction = ir;
  assign oValid       = valid;

`ifdef FETCH_NOP_DELAY_EN
  logic [DELAY_W-1:0] cnt;
  logic               nop_hold;

  assign nop_hold = valid && iReady && (opcode_of(ir) == OP_NOP) &&
                    (ir[DELAY_W-1:0] != '0);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      valid <= 1'b0;
      state <= ST_FETCH;
      cnt   <= '0;
    end else if (iBranchTaken) begin
      pc    <= iBranchTarget;
      valid <= 1'b0;
      state <= ST_FLUSH;
      cnt   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (nop_hold) begin
            valid <= 1'b0;
            cnt   <= ir[DELAY_W-1:0];
            state <= ST_DELAY;
          end else if (advance) begin
            ir    <= iInstruction;
            valid <= 1'b1;
            pc    <= pc + 16'd1;
          end
        end
        ST_FLUSH: state <= ST_FETCH;
        ST_DELAY: begin
          // The last delay cycle already fetches, so the bubble is exactly N cycles.
          if (cnt == DELAY_W'(1)) begin
            ir    <= iInstruction;
            valid <= 1'b1;
            pc    <= pc + 16'd1;
            cnt   <= '0;
            state <= ST_FETCH;
          end else begin
            cnt <= cnt - DELAY_W'(1);
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end
`else
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      valid <= 1'b0;
      state <= ST_FETCH;
    end else if (iBranchTaken) begin
      pc    <= iBranchTarget;
      valid <= 1'b0;
      state <= ST_FLUSH;
    end else begin
      case (state)
        ST_FETCH: begin
          if (advance) begin
            ir    <= iInstruction;
            valid <= 1'b1;
            pc    <= pc + 16'd1;
          end
        end
        ST_FLUSH: state <= ST_FETCH;
        default:  state <= ST_FETCH;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random
// phase, all compared against a bubble-counting stream model of the fetch stage.
import instruction_fetch_pkg::*;

module tb_instruction_fetch;

  localparam logic [15:0] RST_PC = 16'd0;
`ifdef FETCH_NOP_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif
  localparam int EXP_GAP = DELAY_EN ? 4000 : 0;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;

  logic [27:0] rom [0:65535];

  int ncmp = 0;
  int nfail = 0;

  logic [15:0] m_pc;
  logic [27:0] m_ir;
  logic        m_valid;
  int          m_bub;

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress];

  instruction_fetch #(.RESET_PC(RST_PC), .DELAY_W(24)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oAddress     (oAddress),
    .iInstruction (iInstruction),
    .oInstruction (oInstruction),
    .oValid       (oValid),
    .iReady       (iReady),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Stream model: bubbles are cycles in which nothing may be fetched.
  task automatic model_step();
    if (!Reset) begin
      m_pc = RST_PC; m_ir = '0; m_valid = 1'b0; m_bub = 0;
    end else if (iBranchTaken) begin
      m_pc = iBranchTarget; m_valid = 1'b0; m_bub = 1;
    end else if (m_bub > 0) begin
      m_bub--; m_valid = 1'b0;
    end else if (!m_valid || iReady) begin
      if (DELAY_EN && m_valid && m_ir[27:24] == OP_NOP && m_ir[23:0] != 24'd0) begin
        m_valid = 1'b0;
        m_bub = int'(m_ir[23:0]) - 1;
      end else begin
        m_ir = rom[m_pc]; m_valid = 1'b1; m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    model_step();
    #1;
    check("model_addr", {16'd0, oAddress}, {16'd0, m_pc});
    check("model_valid", {31'd0, oValid}, {31'd0, m_valid});
    check("model_instr", {4'd0, oInstruction}, {4'd0, m_ir});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int gap;
    for (int a = 0; a < 65536; a++)
      rom[a] = {4'($urandom_range(1, 6)), 8'($urandom), 16'(a)};
    rom[40] = {OP_NOP, 24'd4000};
    rom[41] = {OP_NOP, 24'd0};
    m_pc = RST_PC; m_ir = '0; m_valid = 1'b0; m_bub = 0;

    Reset = 1'b0; iReady = 1'b1; iBranchTaken = 1'b0; iBranchTarget = '0;
    repeat (3) cyc();
    check("rst_addr", {16'd0, oAddress}, {16'd0, RST_PC});
    check("rst_valid", {31'd0, oValid}, 32'd0);
    check("rst_instr", {4'd0, oInstruction}, 32'd0);

    // Sequential fetch after release
    Reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("seq_addr", {16'd0, oAddress}, 32'(k));
      check("seq_valid", {31'd0, oValid}, 32'd1);
      check("seq_lag", {4'd0, oInstruction}, {4'd0, rom[k-1]});
    end

    // Stall at PC=5
    Reset = 1'b0; cyc(); Reset = 1'b1;
    repeat (5) cyc();
    iReady = 1'b0;
    repeat (3) begin
      cyc();
      check("stall_addr", {16'd0, oAddress}, 32'd5);
      check("stall_instr", {4'd0, oInstruction}, {4'd0, rom[4]});
    end
    iReady = 1'b1;
    cyc();
    check("resume_addr", {16'd0, oAddress}, 32'd6);
    check("resume_instr", {4'd0, oInstruction}, {4'd0, rom[5]});

    // Branch at PC=15 to 8
    n = 0;
    while (oAddress != 16'd15 && n < 50) begin cyc(); n++; end
    check("reach15", {16'd0, oAddress}, 32'd15);
    iBranchTaken = 1'b1; iBranchTarget = 16'd8;
    cyc();
    iBranchTaken = 1'b0;
    check("br_bubble1", {31'd0, oValid}, 32'd0);
    cyc();
    check("br_bubble2", {31'd0, oValid}, 32'd0);
    cyc();
    check("br_valid", {31'd0, oValid}, 32'd1);
    check("br_instr", {4'd0, oInstruction}, {4'd0, rom[8]});

    // Back-to-back branches 9 then 11
    iBranchTaken = 1'b1; iBranchTarget = 16'd9;
    cyc();
    iBranchTarget = 16'd11;
    cyc();
    iBranchTaken = 1'b0;
    cyc();
    check("b2b_no9", {31'd0, (oValid && oInstruction == rom[9])}, 32'd0);
    check("b2b_bubble", {31'd0, oValid}, 32'd0);
    cyc();
    check("b2b_instr", {4'd0, oInstruction}, {4'd0, rom[11]});
    cyc();
    check("b2b_next", {4'd0, oInstruction}, {4'd0, rom[12]});

    // Random phase away from the planted NOPs
    iBranchTaken = 1'b1; iBranchTarget = 16'd200;
    cyc();
    repeat (300) begin
      iReady        = ($urandom_range(0, 9) < 7);
      iBranchTaken  = ($urandom_range(0, 19) == 0);
      iBranchTarget = 16'($urandom_range(100, 60000));
      cyc();
    end

    // NOP with N=4000 followed by NOP with N=0
    iReady = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'd40;
    cyc();
    iBranchTaken = 1'b0;
    cyc(); cyc();
    check("nop_present", {4'd0, oInstruction}, {4'd0, rom[40]});
    cyc();
    gap = 0;
    while (!oValid && gap < 5000) begin gap++; cyc(); end
    check("nop_gap", 32'(gap), 32'(EXP_GAP));
    check("nop_after", {4'd0, oInstruction}, {4'd0, rom[41]});
    cyc();
    check("nop0_nogap", {31'd0, oValid}, 32'd1);
    check("nop0_next", {4'd0, oInstruction}, {4'd0, rom[42]});

    // Reset in the middle of a NOP delay
    iBranchTaken = 1'b1; iBranchTarget = 16'd40;
    cyc();
    iBranchTaken = 1'b0;
    repeat (3) cyc();
    repeat (100) cyc();
    Reset = 1'b0;
    cyc();
    check("mrst_addr", {16'd0, oAddress}, {16'd0, RST_PC});
    check("mrst_valid", {31'd0, oValid}, 32'd0);
    Reset = 1'b1;
    cyc();
    check("mrst_rel_valid", {31'd0, oValid}, 32'd1);
    check("mrst_rel_instr", {4'd0, oInstruction}, {4'd0, rom[RST_PC]});

    // PC wrap from FFFF
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    cyc();
    iBranchTaken = 1'b0;
    cyc();
    check("wrap_pre", {16'd0, oAddress}, 32'h0000FFFF);
    cyc();
    check("wrap_addr", {16'd0, oAddress}, 32'd0);
    check("wrap_instr", {4'd0, oInstruction}, {4'd0, rom[16'hFFFF]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0, meaning the program counter value loaded on reset.
REQ-002 SHALL have parameter DELAY_W, default 24, meaning the width of the NOP delay counter; it equals the NOP immediate field width.
REQ-003 SHALL have port Clock, input, 1, the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port oAddress, output, 16, the current PC, driven to the instruction ROM address input.
REQ-006 SHALL have port iInstruction, input, 28, the combinational ROM word at oAddress.
REQ-007 SHALL have port oInstruction, output, 28, the registered instruction (IR) to decode/execute.
REQ-008 SHALL have port oValid, output, 1, meaning oInstruction holds a live instruction.
REQ-009 SHALL have port iReady, input, 1, meaning downstream accepts oInstruction this cycle.
REQ-010 SHALL have port iBranchTaken, input, 1, a taken BLE or JMP resolved downstream.
REQ-011 SHALL have port iBranchTarget, input, 16, the redirect address, with an 8-bit label zero-extended by execute.

Function
REQ-012 SHALL hold FSM states FETCH, FLUSH and DELAY; DELAY exists only with the macro of REQ-024.
REQ-013 SHALL define "advance" as: state FETCH and (oValid==0 or iReady==1).
REQ-014 On advance, SHALL load IR<=iInstruction, set oValid<=1 and PC<=PC+1; latency is exactly one cycle from oAddress to oInstruction.
REQ-015 While iReady==0 and oValid==1, SHALL hold PC, IR and oValid stable.
REQ-016 SHALL wrap PC 16'hFFFF+1 to 16'h0000 with no flag.
REQ-017 When iBranchTaken==1, SHALL set PC<=iBranchTarget, oValid<=0 and next state FLUSH, regardless of iReady or the current state.
REQ-018 In FLUSH, SHALL keep oValid=0 for that cycle, then return to FETCH; the first post-redirect instruction appears two cycles after iBranchTaken.
REQ-019 If iBranchTaken is asserted again while in FLUSH, SHALL take the newer target and stay in FLUSH for one more cycle.
REQ-020 SHALL give iBranchTaken priority over advance, stall and DELAY.
REQ-021 SHALL drive oAddress directly from the PC register, with no combinational path from any input.

Reset
REQ-022 While Reset==0 at a clock edge, SHALL set PC=RESET_PC, IR=28'd0, oValid=0, state FETCH and delay counter 0.
REQ-023 A reset asserted mid-stall, mid-FLUSH or mid-DELAY SHALL abandon that operation; the first fetch after release is at RESET_PC, with oValid=1 one cycle after release.

Configuration
REQ-024 With FETCH_NOP_DELAY_EN defined: when a NOP (opcode [27:24]==`NOP) with immediate N=[23:0]!=0 is accepted downstream (oValid and iReady), the block SHALL enter DELAY, load counter=N, hold oValid=0 and the PC, decrement once per cycle, and return to FETCH after the cycle in which the counter reaches 1.
REQ-025 With FETCH_NOP_DELAY_EN undefined: NOPs SHALL pass as ordinary instructions, DELAY and the counter SHALL be absent, and N=0 SHALL never delay in either build.

Structure
REQ-026 The opcode encodings (`NOP, `STO, `ADD, `MUL, `BLE, `JMP, `LED) and field bit positions SHALL come from the shared definitions header Defintions.v; no local opcode constants.
REQ-027 The FSM state encodings SHALL be localparams in the shared header.
REQ-028 SHALL be a single module with no sub-module, instantiated directly ahead of ROM.

Verification
REQ-029 Bench SHALL cover: release reset with iReady=1 -> oAddress 0,1,2,... per cycle; oValid=1 from the first cycle after release, with oInstruction lagging oAddress by one.
REQ-030 Bench SHALL cover: iReady=0 for 3 cycles at PC=5 -> oAddress=5 and oInstruction=ROM[4] held; resumes with 6.
REQ-031 Bench SHALL cover: iBranchTaken=1 with target=8 while PC=15 -> oValid=0 for 2 cycles, then oInstruction=ROM[8].
REQ-032 Bench SHALL cover: back-to-back iBranchTaken targets 9 then 11 -> only ROM[11] stream emitted, no ROM[9].
REQ-033 Bench SHALL cover: with FETCH_NOP_DELAY_EN, NOP with N=4000 accepted -> oValid=0 for exactly 4000 cycles; without the macro -> no gap.
REQ-034 Bench SHALL cover: PC preset 16'hFFFF, then advance -> oAddress=0; and Reset=0 mid-DELAY -> PC=0, counter 0, next cycle oValid=1.
